// File: rtl/bga_scan_engine.sv
// bga_scan_engine: walking-zero continuity/short scan for BGA joint test boards.
// Define FAULT_FIFO_EN to build the fault-record FIFO; otherwise its ports are tied off.
module bga_scan_engine #(
   parameter int  N_PAIR      = 86,
   parameter int  DIV_LOG2    = 6,
   parameter int  FAULT_DEPTH = 8,
   localparam int IDX_W       = $clog2(N_PAIR)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              continuous,
   input  logic              abort,
   output logic [N_PAIR-1:0] scan_out,
   input  logic [N_PAIR-1:0] scan_in,
   output logic              busy,
   output logic              done,
   output logic [15:0]       pass_cnt,
   output logic              fault_any,
   output logic [15:0]       fault_cnt,
   output logic [IDX_W-1:0]  first_fault_step,
   output logic [N_PAIR-1:0] first_fault_vec,
   input  logic              fifo_pop,
   output logic              fifo_empty,
   output logic [IDX_W-1:0]  fifo_dout,
   output logic              fifo_overflow
);

   typedef enum logic [1:0] {S_IDLE, S_STEP, S_DONE} state_t;

   state_t              state_q;
   logic [N_PAIR-1:0]   sync1_q, sync2_q, scan_out_q;
   logic [N_PAIR-1:0]   one_lsb, one_hot, exp_vec, mism;
   logic [IDX_W-1:0]    step_q, ff_step_q;
   logic [DIV_LOG2-1:0] div_q;
   logic [N_PAIR-1:0]   ff_vec_q;
   logic [15:0]         pass_cnt_q, fault_cnt_q;
   logic                cont_q, busy_q, done_q, fault_any_q;
   logic                last_step, fault_hit, clear;

   assign one_lsb   = N_PAIR'(1);
   assign one_hot   = one_lsb << step_q;
   assign exp_vec   = ~one_hot;
   assign mism      = sync2_q ^ exp_vec;
   assign last_step = (step_q == IDX_W'(N_PAIR - 1));
   assign fault_hit = (state_q == S_STEP) && (&div_q) && !abort && (|mism);
   assign clear     = (state_q == S_IDLE) && start && !abort;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= scan_in;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         step_q      <= '0;
         div_q       <= '0;
         cont_q      <= 1'b0;
         scan_out_q  <= '1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_cnt_q  <= '0;
         fault_any_q <= 1'b0;
         fault_cnt_q <= '0;
         ff_step_q   <= '0;
         ff_vec_q    <= '0;
      end else begin
         done_q <= 1'b0;
         if (abort) begin
            state_q    <= S_IDLE;
            scan_out_q <= '1;
            busy_q     <= 1'b0;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  scan_out_q <= '1;
                  if (start) begin
                     state_q     <= S_STEP;
                     busy_q      <= 1'b1;
                     cont_q      <= continuous;
                     step_q      <= '0;
                     div_q       <= '0;
                     scan_out_q  <= ~one_lsb;
                     pass_cnt_q  <= '0;
                     fault_any_q <= 1'b0;
                     fault_cnt_q <= '0;
                     ff_step_q   <= '0;
                     ff_vec_q    <= '0;
                  end
               end
               S_STEP: begin
                  div_q <= div_q + DIV_LOG2'(1);
                  if (&div_q) begin
                     if (|mism) begin
                        fault_any_q <= 1'b1;
                        if (fault_cnt_q != 16'hFFFF)
                           fault_cnt_q <= fault_cnt_q + 16'd1;
                        if (!fault_any_q) begin
                           ff_step_q <= step_q;
                           ff_vec_q  <= mism;
                        end
                     end
                     if (!last_step) begin
                        step_q     <= step_q + IDX_W'(1);
                        scan_out_q <= ~{one_hot[N_PAIR-2:0], 1'b0};
                     end else begin
                        pass_cnt_q <= pass_cnt_q + 16'd1;
                        step_q     <= '0;
                        if (cont_q) begin
                           scan_out_q <= ~one_lsb;
                        end else begin
                           state_q    <= S_DONE;
                           scan_out_q <= '1;
                           done_q     <= 1'b1;
                        end
                     end
                  end
               end
               S_DONE: begin
                  state_q    <= S_IDLE;
                  busy_q     <= 1'b0;
                  scan_out_q <= '1;
               end
               default: begin
                  state_q    <= S_IDLE;
                  busy_q     <= 1'b0;
                  scan_out_q <= '1;
               end
            endcase
         end
      end
   end

   assign scan_out         = scan_out_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass_cnt         = pass_cnt_q;
   assign fault_any        = fault_any_q;
   assign fault_cnt        = fault_cnt_q;
   assign first_fault_step = ff_step_q;
   assign first_fault_vec  = ff_vec_q;

`ifdef FAULT_FIFO_EN
   localparam int PW = $clog2(FAULT_DEPTH);

   logic [IDX_W-1:0] mem_q [FAULT_DEPTH];
   logic [PW:0]      wr_q, rd_q;
   logic             ovf_q, f_empty, f_full, do_pop, do_push;

   assign f_empty = (wr_q == rd_q);
   assign f_full  = (wr_q[PW] != rd_q[PW]) &&
                    (wr_q[PW-1:0] == rd_q[PW-1:0]);
   assign do_pop  = fifo_pop && !f_empty && !clear;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push = fault_hit && (!f_full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push)
         mem_q[wr_q[PW-1:0]] <= step_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         ovf_q <= 1'b0;
      end else if (clear) begin
         wr_q  <= '0;
         rd_q  <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (do_push)
            wr_q <= wr_q + (PW+1)'(1);
         if (do_pop)
            rd_q <= rd_q + (PW+1)'(1);
         if (fault_hit && !do_push)
            ovf_q <= 1'b1;
      end
   end

   assign fifo_empty    = f_empty;
   assign fifo_dout     = f_empty ? '0 : mem_q[rd_q[PW-1:0]];
   assign fifo_overflow = ovf_q;
`else
   localparam int UNUSED_DEPTH = FAULT_DEPTH;
   logic unused_fifo;

   assign unused_fifo   = fifo_pop ^ fault_hit ^ clear;
   assign fifo_empty    = 1'b1;
   assign fifo_dout     = '0;
   assign fifo_overflow = 1'b0;
`endif

endmodule
